// File: rtl/jt51_wrseq.sv
// jt51_wrseq - host write sequencer for the JT51 register block.
//
// CPU register writes (address/data pairs) are queued in a small circular
// FIFO and replayed one at a time as the two-phase bus transaction the JT51
// register block expects:
//   address write (a0=0), one idle cycle, data write (a0=1),
//   then wait for the register block's busy flag to rise and fall.
// The CPU can therefore push writes back to back without polling busy.
//
// Parameters
//   DEPTH     : FIFO entries, power of two, 2..256
//   SKIP_ADDR : 1 = omit the address phase when the address repeats
//
// Ports
//   clk, rst_n        : clock (shared with the JT51 core), async active-low reset
//   wr_req            : host push strobe, one entry per cycle
//   wr_addr, wr_data  : register address / data to push
//   full, empty       : FIFO status (registered)
//   level             : number of stored entries
//   ovf, ovf_clr      : sticky overflow flag (dropped push) and its clear
//   idle              : FIFO empty and sequencer idle
//   jt_write, jt_a0,
//   jt_din            : drive write / a0 / din of the register block
//   jt_busy           : busy flag from the register block
module jt51_wrseq #(
  parameter int DEPTH     = 16,
  parameter bit SKIP_ADDR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_req,
  input  logic [7:0]               wr_addr,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     idle,
  output logic                     jt_write,
  output logic                     jt_a0,
  output logic [7:0]               jt_din,
  input  logic                     jt_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_BSYH,
    S_BSYL
  } state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_idle;
  logic          w_push;
  logic          w_pop;
  logic          w_skip;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_hold_addr;
  logic [7:0]    r_hold_data;
  logic [7:0]    r_last_addr;
  logic          r_last_vld;
  logic          r_bsy_cnt;

  logic          r_write;
  logic          r_a0;
  logic [7:0]    r_din;

  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_level;
  assign ovf      = r_ovf;
  assign idle     = r_idle;
  assign jt_write = r_write;
  assign jt_a0    = r_a0;
  assign jt_din   = r_din;

  // Push is gated by the registered full flag, so a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign w_push      = wr_req && !r_full;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // The head entry may skip its address phase when it repeats the address
  // the register block already latched.
  assign w_skip = SKIP_ADDR && r_last_vld && (r_mem[r_rptr][15:8] == r_last_addr);

  // FIFO storage has no reset: contents are only meaningful below r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {wr_addr, wr_data};
    end
  end

  // Pointers, occupancy and status flags.  full/empty/idle are computed from
  // the next-state values so they are valid registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
      r_idle  <= (w_state_nxt == S_IDLE) && (w_level_nxt == '0);
      // A dropped push beats a simultaneous clear.
      if (wr_req && r_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.  BSYH gives the register block two cycles to raise
  // busy; if it never does, move on rather than stall forever.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_skip ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: w_state_nxt = S_GAP;
      S_GAP:  w_state_nxt = S_DATA;
      S_DATA: w_state_nxt = S_BSYH;
      S_BSYH: begin
        if (jt_busy || r_bsy_cnt) begin
          w_state_nxt = S_BSYL;
        end
      end
      S_BSYL: begin
        if (!jt_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding registers, last-address tracking and the BSYH timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_addr <= 8'h00;
      r_hold_data <= 8'h00;
      r_last_addr <= 8'h00;
      r_last_vld  <= 1'b0;
      r_bsy_cnt   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_hold_addr <= r_mem[r_rptr][15:8];
        r_hold_data <= r_mem[r_rptr][7:0];
      end
      if (r_state == S_DATA) begin
        r_last_addr <= r_hold_addr;
        r_last_vld  <= 1'b1;
      end
      r_bsy_cnt <= (r_state == S_BSYH);
    end
  end

  // Bus outputs are registered from the current state, so the pins follow
  // the state by one cycle.  a0/din hold their value while write is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_a0    <= 1'b0;
      r_din   <= 8'h00;
    end else begin
      r_write <= (r_state == S_ADDR) || (r_state == S_DATA);
      if (r_state == S_ADDR) begin
        r_a0  <= 1'b0;
        r_din <= r_hold_addr;
      end else if (r_state == S_DATA) begin
        r_a0  <= 1'b1;
        r_din <= r_hold_data;
      end
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Testbench for jt51_wrseq.  Two instances share the host side: the main one
// (SKIP_ADDR=1) sees a busy model, the second (SKIP_ADDR=0) has busy tied low
// so every one of its transactions goes through the busy timeout.
module tb_jt51_wrseq;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          wrReq;
  logic [7:0]    wrAddr;
  logic [7:0]    wrData;
  logic          ovfClr;
  logic          jtBusy;

  logic          full, empty, ovf, idle, jtWrite, jtA0;
  logic [LW-1:0] level;
  logic [7:0]    jtDin;

  logic          nsFull, nsEmpty, nsOvf, nsIdle, nsWrite, nsA0;
  logic [LW-1:0] nsLevel;
  logic [7:0]    nsDin;

  int checks   = 0;
  int failures = 0;

  // Bus transactions are stored as {a0, din}.
  logic [8:0] obsMain[$];
  logic [8:0] obsNs[$];
  logic [8:0] expMain[$];
  logic [8:0] expNs[$];
  logic       mLastVld;
  logic [7:0] mLastAddr;

  int   busyMode  = 0;
  int   lastMode  = 0;
  int   delayLeft = 0;
  int   highLeft  = 0;
  int   busyDelay = 1;
  int   busyLen   = 32;
  logic prevWrMain = 1'b0;
  logic prevWrNs   = 1'b0;

  jt51_wrseq #(.DEPTH(DEPTH), .SKIP_ADDR(1'b1)) dut (
    .clk(clk), .rst_n(rstN), .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .ovf_clr(ovfClr),
    .idle(idle), .jt_write(jtWrite), .jt_a0(jtA0), .jt_din(jtDin), .jt_busy(jtBusy)
  );

  jt51_wrseq #(.DEPTH(DEPTH), .SKIP_ADDR(1'b0)) dutNoSkip (
    .clk(clk), .rst_n(rstN), .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData),
    .full(nsFull), .empty(nsEmpty), .level(nsLevel), .ovf(nsOvf), .ovf_clr(ovfClr),
    .idle(nsIdle), .jt_write(nsWrite), .jt_a0(nsA0), .jt_din(nsDin), .jt_busy(1'b0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: every accepted entry yields an address write unless the
  // instance skips repeated addresses and this one matches the last issued
  // address, followed by a data write.
  task automatic modelAccept(input logic [7:0] a, input logic [7:0] d);
    if (!(mLastVld && a == mLastAddr)) expMain.push_back({1'b0, a});
    expMain.push_back({1'b1, d});
    mLastVld  = 1'b1;
    mLastAddr = a;
    expNs.push_back({1'b0, a});
    expNs.push_back({1'b1, d});
  endtask

  // Called at a negedge; returns at the next negedge with wrReq low again.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit accepted);
    wrReq  = 1'b1;
    wrAddr = a;
    wrData = d;
    if (accepted) modelAccept(a, d);
    @(negedge clk);
    wrReq = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n = 0;
    while (!(idle && nsIdle && !jtBusy && delayLeft == 0 && highLeft == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idleTimeout"}, 32'(n >= bound), 32'd0);
  endtask

  task automatic compareStreams(input string tag, input bit withNs);
    checkOutput({tag, "_mainLen"}, 32'(obsMain.size()), 32'(expMain.size()));
    for (int i = 0; i < expMain.size() && i < obsMain.size(); i++)
      checkOutput($sformatf("%s_main%0d", tag, i), 32'(obsMain[i]), 32'(expMain[i]));
    if (withNs) begin
      checkOutput({tag, "_nsLen"}, 32'(obsNs.size()), 32'(expNs.size()));
      for (int i = 0; i < expNs.size() && i < obsNs.size(); i++)
        checkOutput($sformatf("%s_ns%0d", tag, i), 32'(obsNs[i]), 32'(expNs[i]));
    end
    checkOutput({tag, "_level"}, 32'(level), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    obsMain.delete(); expMain.delete(); obsNs.delete(); expNs.delete();
  endtask

  // Bus monitor: log every write cycle and flag two write-high cycles in a row.
  always @(negedge clk) begin
    if (jtWrite) begin
      obsMain.push_back({jtA0, jtDin});
      checkOutput("mainWriteGap", 32'(prevWrMain), 32'd0);
    end
    if (nsWrite) begin
      obsNs.push_back({nsA0, nsDin});
      checkOutput("nsWriteGap", 32'(prevWrNs), 32'd0);
    end
    prevWrMain = jtWrite;
    prevWrNs   = nsWrite;
  end

  // Register-block busy model.  Mode 0: tied low, 1: held high,
  // 2: after a data write, busy rises busyDelay+1 cycles later for busyLen cycles.
  always @(negedge clk) begin
    #1;
    if (busyMode != 2 || lastMode != 2) begin
      jtBusy    = (busyMode == 1);
      delayLeft = 0;
      highLeft  = 0;
    end else begin
      if (delayLeft > 0) begin
        delayLeft--;
        if (delayLeft == 0) begin
          jtBusy   = 1'b1;
          highLeft = busyLen;
        end
      end else if (highLeft > 0) begin
        highLeft--;
        if (highLeft == 0) jtBusy = 1'b0;
      end
      if (jtWrite && jtA0) delayLeft = busyDelay + 1;
    end
    lastMode = busyMode;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] addrSet [3];
    int n;
    addrSet[0] = 8'h08; addrSet[1] = 8'h20; addrSet[2] = 8'h28;
    rstN = 1'b0; wrReq = 1'b0; wrAddr = 8'h00; wrData = 8'h00; ovfClr = 1'b0;
    busyMode = 2; busyDelay = 1; busyLen = 32;
    mLastVld = 1'b0; mLastAddr = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstWrite", 32'(jtWrite), 32'd0);
    checkOutput("rstA0", 32'(jtA0), 32'd0);
    checkOutput("rstDin", 32'(jtDin), 32'd0);
    checkOutput("rstFull", 32'(full), 32'd0);
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstOvf", 32'(ovf), 32'd0);
    checkOutput("rstIdle", 32'(idle), 32'd1);
    rstN = 1'b1;
    @(negedge clk);

    // First transaction timing with a 32-cycle busy pulse
    wrReq = 1'b1; wrAddr = 8'h20; wrData = 8'hC7;
    modelAccept(8'h20, 8'hC7);
    @(posedge clk); #1;
    checkOutput("t1PushEmpty", 32'(empty), 32'd0);
    checkOutput("t1PushLevel", 32'(level), 32'd1);
    checkOutput("t1PushIdle", 32'(idle), 32'd0);
    @(negedge clk); wrReq = 1'b0;
    @(posedge clk); #1;
    checkOutput("t1PopWrite", 32'(jtWrite), 32'd0);
    checkOutput("t1PopLevel", 32'(level), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1AddrPhase", {29'd0, jtWrite, jtA0, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    checkOutput("t1AddrDin", 32'(jtDin), 32'h20);
    @(posedge clk); #1;
    checkOutput("t1GapWrite", 32'(jtWrite), 32'd0);
    checkOutput("t1GapDin", 32'(jtDin), 32'h20);
    @(posedge clk); #1;
    checkOutput("t1DataPhase", {29'd0, jtWrite, jtA0, 1'b0}, {29'd0, 1'b1, 1'b1, 1'b0});
    checkOutput("t1DataDin", 32'(jtDin), 32'hC7);
    @(negedge clk);
    n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t1IdleTimeout", 32'(n >= 200), 32'd0);
    checkOutput("t1IdleBusyLow", 32'(jtBusy), 32'd0);
    checkOutput("t1IdleAfterBusy", 32'(n >= 32), 32'd1);
    waitIdle("t1", 500);
    compareStreams("t1", 1'b1);

    // Repeated address: main skips the second address phase, no-skip does not
    busyLen = 3;
    applyStimulus(8'h28, 8'h4A, 1'b1);
    applyStimulus(8'h28, 8'h4B, 1'b1);
    waitIdle("t2", 500);
    compareStreams("t2", 1'b1);

    // Randomized bursts that never exceed the FIFO depth
    for (int r = 0; r < 8; r++) begin
      busyDelay = $urandom_range(0, 3);
      busyLen   = $urandom_range(1, 6);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        applyStimulus(addrSet[$urandom_range(0, 2)], 8'($urandom), 1'b1);
      end
      waitIdle($sformatf("rnd%0d", r), 3000);
      compareStreams($sformatf("rnd%0d", r), 1'b1);
    end

    // Fill with busy held high: one entry is in flight, DEPTH stored, last dropped
    busyMode = 1; busyDelay = 1; busyLen = 3;
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(8'h60 + 8'(i), 8'(i), (i <= DEPTH));
    checkOutput("fillLevel", 32'(level), 32'(DEPTH));
    checkOutput("fillFull", 32'(full), 32'd1);
    checkOutput("fillOvf", 32'(ovf), 32'd1);
    checkOutput("fillEmpty", 32'(empty), 32'd0);
    wrReq = 1'b1; wrAddr = 8'hEE; wrData = 8'hEE; ovfClr = 1'b1;
    @(posedge clk); #1;
    checkOutput("ovfSetWins", 32'(ovf), 32'd1);
    checkOutput("ovfDropLevel", 32'(level), 32'(DEPTH));
    @(negedge clk); wrReq = 1'b0;
    @(posedge clk); #1;
    checkOutput("ovfCleared", 32'(ovf), 32'd0);
    @(negedge clk); ovfClr = 1'b0;
    // Release busy while pushing: the pop cycle must not admit the push
    busyMode = 2;
    wrReq = 1'b1; wrAddr = 8'h77; wrData = 8'h99;
    @(posedge clk); #1;
    checkOutput("relDropOvf", 32'(ovf), 32'd1);
    checkOutput("relDropLevel", 32'(level), 32'(DEPTH));
    @(posedge clk); #1;
    checkOutput("popNoAdmitLevel", 32'(level), 32'(DEPTH - 1));
    checkOutput("popNoAdmitFull", 32'(full), 32'd0);
    @(negedge clk); wrReq = 1'b0;
    waitIdle("fill", 5000);
    compareStreams("fill", 1'b0);

    // Reset during the data phase with entries still queued
    for (int i = 0; i < 4; i++) applyStimulus(8'h50, 8'h10 + 8'(i), 1'b1);
    n = 0;
    while (!(jtWrite && jtA0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstDataTimeout", 32'(n >= 50), 32'd0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstWrite", 32'(jtWrite), 32'd0);
    checkOutput("midRstLevel", 32'(level), 32'd0);
    checkOutput("midRstEmpty", 32'(empty), 32'd1);
    checkOutput("midRstIdle", 32'(idle), 32'd1);
    checkOutput("midRstDin", 32'(jtDin), 32'd0);
    obsMain.delete(); expMain.delete(); obsNs.delete(); expNs.delete();
    mLastVld = 1'b0;
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);
    applyStimulus(8'h50, 8'hAB, 1'b1);
    waitIdle("postRst", 500);
    compareStreams("postRst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
